hci_mem_bank_resp_unit: RTL

//  Per-bank response/atomic unit between one target port of the TCDM log crossbar and one SRAM bank.

---
 rtl/hci_mem_bank_resp_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hci_mem_bank_resp_unit.sv
// rtl/hci_mem_bank_resp_unit.sv - per-bank response pipeline and test-and-set unit
module hci_mem_bank_resp_unit #(
    parameter int unsigned AWM     = 10,
    parameter int unsigned DW      = 32,
    parameter int unsigned BW      = 8,
    parameter int unsigned UW      = 0,
    parameter int unsigned IW      = 8,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned TS_EN   = 1,
    localparam int unsigned BEW    = DW / BW,
    localparam int unsigned UWW    = (UW > 0) ? UW : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic [AWM-1:0]   add_i,
    input  logic             wen_i,
    input  logic [BEW-1:0]   be_i,
    input  logic [DW-1:0]    data_i,
    input  logic [UWW-1:0]   user_i,
    input  logic [IW-1:0]    id_i,
    input  logic             ts_set_i,
    output logic             r_valid_o,
    output logic [DW-1:0]    r_data_o,
    output logic [UWW-1:0]   r_user_o,
    output logic [IW-1:0]    r_id_o,
    output logic             mem_req_o,
    input  logic             mem_gnt_i,
    output logic [AWM-1:0]   mem_add_o,
    output logic             mem_wen_o,
    output logic [BEW-1:0]   mem_be_o,
    output logic [DW-1:0]    mem_data_o,
    output logic [UWW-1:0]   mem_user_o,
    input  logic [DW-1:0]    mem_r_data_i,
    input  logic [UWW-1:0]   mem_r_user_i,
    output logic             busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        TS_WR = 1'b1
    } state_e;

    state_e             state_q;
    logic [AWM-1:0]     ts_addr_q;
    logic [MEM_LAT-1:0] vld_q;
    logic [IW-1:0]      id_q [MEM_LAT];

    logic accept;
    logic ts_start;

    // Grant is held low in reset, during a flush and while the TS write owns the bank.
    assign gnt_o    = rst_ni & ~clear_i & (state_q == IDLE) & mem_gnt_i;
    assign accept   = req_i & gnt_o;
    assign ts_start = (TS_EN != 0) & accept & ts_set_i & wen_i;

    // Bank port: pass-through in IDLE, internal all-ones write of the latched address in TS_WR.
    always_comb begin
        mem_req_o  = rst_ni & ~clear_i & req_i;
        mem_add_o  = add_i;
        mem_wen_o  = wen_i;
        mem_be_o   = be_i;
        mem_data_o = data_i;
        mem_user_o = (UW > 0) ? user_i : '0;
        if (state_q == TS_WR) begin
            mem_req_o  = rst_ni & ~clear_i;
            mem_add_o  = ts_addr_q;
            mem_wen_o  = 1'b0;
            mem_be_o   = '1;
            mem_data_o = '1;
            mem_user_o = '0;
        end
    end

    // Test-and-set sequencing: the locked read moves to TS_WR until the set-write is granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ts_addr_q <= '0;
        end else if (clear_i) begin
            state_q   <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ts_start) begin
                        state_q   <= TS_WR;
                        ts_addr_q <= add_i;
                    end
                end
                TS_WR: begin
                    if (mem_gnt_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Response tracking: every external accept shifts through MEM_LAT stages with its ID.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < MEM_LAT; i++) begin
                id_q[i] <= '0;
            end
        end else if (clear_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= accept;
            id_q[0]  <= id_i;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    assign r_valid_o = vld_q[MEM_LAT-1];
    assign r_id_o    = id_q[MEM_LAT-1];
    assign r_data_o  = mem_r_data_i;
    assign r_user_o  = (UW > 0) ? mem_r_user_i : '0;
    assign busy_o    = (|vld_q) | (state_q == TS_WR);

endmodule
